mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage; consumes the two register-file read operands (rs, rt) and holds the architectural HI/LO registers.
- Implements MULT, MULTU, DIV and DIVU. Each operation takes a fixed multi-cycle latency.
- Provides HI/LO to the MFHI/MFLO writeback path and accepts MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported; HI/LO are WIDTH bits each.
- ITER, 32, number of iteration cycles. Must equal WIDTH.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request to begin an operation. Sampled only when idle.
- op  in  2  operation select: MULT, MULTU, DIV, DIVU.
- rs_data  in  32  operand A (multiplicand / dividend), from ReadData1.
- rt_data  in  32  operand B (multiplier / divisor), from ReadData2.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  32  MTHI/MTLO write data.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when HI/LO receive a result.
- hi  out  32  HI register (registered).
- lo  out  32  LO register (registered).

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset state: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation aborts the operation and discards its result.
- States:
  - IDLE: start=1 at edge E0 latches op, |rs|, |rt| and the sign flags, then goes to CALC with count=0. Signed ops take operand magnitudes; unsigned ops use operands as-is.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. After ITER steps (edges E1..E32) goes to FIX.
  - FIX: applies sign correction and writes HI/LO at edge E33, sets done=1 and returns to IDLE.
- Handshake timing: busy = (state != IDLE), so it is high from the cycle after E0 through the cycle after E32. done is registered and high only in the cycle after E33, the same cycle busy returns to 0. Total latency start-to-result is 34 edges.
- start while busy: ignored; the operands are not re-latched. The pipeline must stall on busy.
- Multiply: 64-bit product, HI = product[63:32], LO = product[31:0]. MULT negates the full 64-bit product if operand signs differ.
- Divide: LO = quotient, HI = remainder.
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend.
  - Overflow case -2^31 / -1: LO = 0x80000000, HI = 0.
- Divide by zero (rt_data=0, DIV or DIVU): LO = 0xFFFFFFFF, HI = rs_data (original, unsigned form). Sign fix is bypassed. Latency is the same 34 edges.
- MTHI/MTLO: in IDLE with start=0, hi_we/lo_we load wdata into hi/lo at the edge, and both may be asserted in the same cycle. They are ignored while busy, and ignored when start=1 in the same cycle (start has priority).
- Read side: hi/lo hold their previous values throughout an operation and change only at the FIX edge, on an MTHI/MTLO write, or on reset.

Decomposition:
- Shared package mips_pkg:
  - Op encodings: MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11.
  - State encodings: MD_IDLE, MD_CALC, MD_FIX.
  - Constant WIDTH=32.
- One sub-module, md_abs_neg: combinational 64-bit conditional two's-complement negate. It is used for operand magnitude at start and for result sign fix in FIX.
- The FSM, counter and datapath registers stay in mult_div_unit.

Test Plan:
- Reset then MULTU, rs=0xFFFFFFFF, rt=0x00000002 -> busy high for 33 cycles; done pulses once; HI=0x00000001, LO=0xFFFFFFFE.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21). DIV rs=-7, rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- Boundary DIV cases:
  - DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
  - DIVU rs=100, rt=0 -> LO=0xFFFFFFFF, HI=100, done at edge E33.
- start asserted again 5 cycles into a DIVU 100/7 -> ignored; result is LO=14, HI=2; exactly one done pulse.
- MTHI 0xAAAA5555 in IDLE -> hi updates next cycle. hi_we asserted while busy -> hi unchanged. start and lo_we in the same cycle -> lo_we dropped.
- rst asserted 10 cycles into MULTU 3*5 -> next cycle busy=0, done=0, hi=lo=0; no done pulse afterwards.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mips_pkg;

  localparam int unsigned WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } mdOp_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } mdState_t;

  // Divide ops share op[1]; signed ops have op[0] clear.
  function automatic logic isDivOp(input mdOp_t op);
    return op[1];
  endfunction

  function automatic logic isSignedOp(input mdOp_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage request/response bundle for the multiply/divide unit.
interface mult_div_unit_if;
  import mips_pkg::*;

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/md_abs_neg.sv
// Combinational conditional two's-complement negate.
module md_abs_neg #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result_c
);

  assign result_c = negate ? W'(~value + W'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
module mult_div_unit #(
  parameter int unsigned WIDTH = mips_pkg::WIDTH,
  parameter int unsigned ITER  = 32
) (
  input  logic          clk,
  input  logic          rst,
  mult_div_unit_if.slave bus
);
  import mips_pkg::*;

  localparam int unsigned CNT_W  = $clog2(ITER);
  localparam int unsigned PROD_W = 2 * WIDTH;

  mdState_t         state, stateNext;
  logic [CNT_W-1:0] count;
  mdOp_t            opReg;
  logic             signA, signB, divZero;
  logic [WIDTH-1:0] origA, operand, accHi, accLo;
  logic [WIDTH-1:0] hiReg, loReg;
  logic             busyReg, doneReg, busyNext, doneNext;

  mdOp_t            opIn;
  logic             inSigned, lastStep;
  logic [WIDTH-1:0] absA, absB;

  assign opIn     = mdOp_t'(bus.op);
  assign inSigned = isSignedOp(opIn);
  assign lastStep = (count == CNT_W'(ITER - 1));

  // Operand magnitudes for signed ops; unsigned ops pass through.
  md_abs_neg #(.W(WIDTH)) uAbsA (
    .value(bus.rs_data), .negate(inSigned & bus.rs_data[WIDTH-1]), .result_c(absA)
  );
  md_abs_neg #(.W(WIDTH)) uAbsB (
    .value(bus.rt_data), .negate(inSigned & bus.rt_data[WIDTH-1]), .result_c(absB)
  );

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
  logic [WIDTH:0] mulSum, divShift, divDiff;
  assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
  assign divShift = {accHi, accLo[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, operand};

  // Sign correction; sign flags are zero for unsigned ops so no op check is needed.
  logic [PROD_W-1:0] prodFix;
  logic [WIDTH-1:0]  quoFix, remFix;
  md_abs_neg #(.W(PROD_W)) uFixProd (
    .value({accHi, accLo}), .negate(signA ^ signB), .result_c(prodFix)
  );
  md_abs_neg #(.W(WIDTH)) uFixQuo (
    .value(accLo), .negate(signA ^ signB), .result_c(quoFix)
  );
  md_abs_neg #(.W(WIDTH)) uFixRem (
    .value(accHi), .negate(signA), .result_c(remFix)
  );

  // State register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MD_IDLE;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      state   <= stateNext;
      busyReg <= busyNext;
      doneReg <= doneNext;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      MD_IDLE: if (bus.start) stateNext = MD_CALC;
      MD_CALC: if (lastStep)  stateNext = MD_FIX;
      MD_FIX:  stateNext = MD_IDLE;
      default: stateNext = MD_IDLE;
    endcase
  end

  // Handshake outputs, registered one cycle later to line up with the state.
  always_comb begin
    busyNext = 1'b0;
    doneNext = 1'b0;
    busyNext = (stateNext != MD_IDLE);
    doneNext = (state == MD_FIX);
  end

  // Operand latch, iteration datapath, counter and HI/LO update.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      opReg   <= MD_MULT;
      signA   <= 1'b0;
      signB   <= 1'b0;
      divZero <= 1'b0;
      origA   <= '0;
      operand <= '0;
      accHi   <= '0;
      accLo   <= '0;
      hiReg   <= '0;
      loReg   <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (bus.start) begin
            opReg   <= opIn;
            signA   <= inSigned & bus.rs_data[WIDTH-1];
            signB   <= inSigned & bus.rt_data[WIDTH-1];
            divZero <= isDivOp(opIn) && (bus.rt_data == '0);
            origA   <= bus.rs_data;
            accHi   <= '0;
            count   <= '0;
            if (isDivOp(opIn)) begin
              accLo   <= absA;
              operand <= absB;
            end else begin
              accLo   <= absB;
              operand <= absA;
            end
          end else begin
            if (bus.hi_we) hiReg <= bus.wdata;
            if (bus.lo_we) loReg <= bus.wdata;
          end
        end
        MD_CALC: begin
          count <= count + CNT_W'(1);
          if (isDivOp(opReg)) begin
            if (!divDiff[WIDTH]) begin
              accHi <= divDiff[WIDTH-1:0];
              accLo <= {accLo[WIDTH-2:0], 1'b1};
            end else begin
              accHi <= divShift[WIDTH-1:0];
              accLo <= {accLo[WIDTH-2:0], 1'b0};
            end
          end else begin
            accHi <= mulSum[WIDTH:1];
            accLo <= {mulSum[0], accLo[WIDTH-1:1]};
          end
        end
        MD_FIX: begin
          count <= '0;
          if (!isDivOp(opReg)) begin
            {hiReg, loReg} <= prodFix;
          end else if (divZero) begin
            hiReg <= origA;
            loReg <= '1;
          end else begin
            hiReg <= remFix;
            loReg <= quoFix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busyReg;
  assign bus.done = doneReg;
  assign bus.hi   = hiReg;
  assign bus.lo   = loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, corner sequences, random vs reference model.
module tb_mult_div_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_div_unit_if mdBus();

  mult_div_unit u_dut (
    .clk(clk),
    .rst(rst),
    .bus(mdBus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference results straight from the arithmetic definition of each op.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = '0;
    el = '0;
    case (op)
      MD_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        {eh, el} = p;
      end
      MD_MULT: begin
        p = 64'(sa * sb);
        {eh, el} = p;
      end
      MD_DIVU: begin
        if (b == 0) begin el = 32'hFFFF_FFFF; eh = a; end
        else begin el = a / b; eh = a % b; end
      end
      default: begin
        if (b == 0) begin el = 32'hFFFF_FFFF; eh = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin el = 32'h8000_0000; eh = 0; end
        else begin el = 32'(sa / sb); eh = 32'(sa % sb); end
      end
    endcase
  endfunction

  // Runs one operation and checks timing, hold behaviour and result.
  // restartAt: cycle index at which a second start is pulsed (-1 none).
  // weAt: cycle index at which hi_we/lo_we are pulsed while busy (-1 none).
  task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo,
                       input int restartAt, input int weAt, input bit weWithStart);
    logic [31:0] hiBefore, loBefore;
    int busyCnt, doneCnt, doneEdge;
    bit held;
    hiBefore = mdBus.hi;
    loBefore = mdBus.lo;
    busyCnt  = 0;
    doneCnt  = 0;
    doneEdge = -1;
    held     = 1'b1;
    mdBus.start   = 1'b1;
    mdBus.op      = op;
    mdBus.rs_data = a;
    mdBus.rt_data = b;
    if (weWithStart) begin
      mdBus.lo_we = 1'b1;
      mdBus.wdata = 32'h5A5A_5A5A;
    end
    tick();
    mdBus.start = 1'b0;
    mdBus.lo_we = 1'b0;
    if (mdBus.busy) busyCnt++;
    if (mdBus.done) doneCnt++;
    for (int i = 1; i <= 40 && doneEdge < 0; i++) begin
      if (i == restartAt) begin
        mdBus.start   = 1'b1;
        mdBus.op      = MD_MULT;
        mdBus.rs_data = 32'd3;
        mdBus.rt_data = 32'd3;
      end
      if (i == weAt) begin
        mdBus.hi_we = 1'b1;
        mdBus.lo_we = 1'b1;
        mdBus.wdata = 32'hDEAD_BEEF;
      end
      tick();
      mdBus.start = 1'b0;
      mdBus.hi_we = 1'b0;
      mdBus.lo_we = 1'b0;
      if (mdBus.busy) busyCnt++;
      if (mdBus.done) begin
        doneCnt++;
        doneEdge = i;
      end else if (mdBus.hi !== hiBefore || mdBus.lo !== loBefore) begin
        held = 1'b0;
      end
    end
    check({name, ".done_edge"}, 64'(doneEdge), 64'd33);
    check({name, ".busy_cycles"}, 64'(busyCnt), 64'd33);
    check({name, ".busy_at_done"}, 64'(mdBus.busy), 64'd0);
    check({name, ".hilo_hold"}, 64'(held), 64'd1);
    check({name, ".hi"}, 64'(mdBus.hi), 64'(expHi));
    check({name, ".lo"}, 64'(mdBus.lo), 64'(expLo));
    repeat (3) begin
      tick();
      if (mdBus.done) doneCnt++;
    end
    check({name, ".done_pulses"}, 64'(doneCnt), 64'd1);
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0] ra, rb, mh, ml, hiPrev, loPrev;
    logic [1:0]  rop;
    int doneCnt;

    vecs[0] = '{"multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[1] = '{"mult_neg",  MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{"div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{"divu_zero", MD_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
    vecs[5] = '{"divu_7",    MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[6] = '{"div_zero",  MD_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[7] = '{"mult_min",  MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{"div_negb",  MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[9] = '{"multu_0",   MD_MULTU, 32'd0,         32'h1234_5678, 32'h0000_0000, 32'h0000_0000};

    mdBus.start   = 1'b0;
    mdBus.op      = MD_MULT;
    mdBus.rs_data = '0;
    mdBus.rt_data = '0;
    mdBus.hi_we   = 1'b0;
    mdBus.lo_we   = 1'b0;
    mdBus.wdata   = '0;
    rst = 1'b1;
    tick();
    tick();
    check("reset.busy", 64'(mdBus.busy), 64'd0);
    check("reset.done", 64'(mdBus.done), 64'd0);
    check("reset.hi", 64'(mdBus.hi), 64'd0);
    check("reset.lo", 64'(mdBus.lo), 64'd0);
    rst = 1'b0;
    tick();

    // Directed vector table.
    foreach (vecs[i])
      runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo, -1, -1, 1'b0);

    // Multi-cycle corner cases.
    runOp("restart_ignored", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 5, -1, 1'b0);
    runOp("we_while_busy", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, -1, 3, 1'b0);
    runOp("lo_we_with_start", MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, -1, -1, 1'b1);

    // Randomized ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = 32'($urandom);
      endcase
      model(rop, ra, rb, mh, ml);
      runOp($sformatf("rand%0d", n), rop, ra, rb, mh, ml, -1, -1, 1'b0);
    end

    // MTHI / MTLO in idle.
    loPrev = mdBus.lo;
    mdBus.hi_we = 1'b1;
    mdBus.wdata = 32'hAAAA_5555;
    tick();
    mdBus.hi_we = 1'b0;
    check("mthi.hi", 64'(mdBus.hi), 64'h0000_0000_AAAA_5555);
    check("mthi.lo_kept", 64'(mdBus.lo), 64'(loPrev));
    hiPrev = mdBus.hi;
    mdBus.lo_we = 1'b1;
    mdBus.wdata = 32'h1234_5678;
    tick();
    mdBus.lo_we = 1'b0;
    check("mtlo.lo", 64'(mdBus.lo), 64'h0000_0000_1234_5678);
    check("mtlo.hi_kept", 64'(mdBus.hi), 64'(hiPrev));
    mdBus.hi_we = 1'b1;
    mdBus.lo_we = 1'b1;
    mdBus.wdata = 32'h0F0F_0F0F;
    tick();
    mdBus.hi_we = 1'b0;
    mdBus.lo_we = 1'b0;
    check("mthilo.hi", 64'(mdBus.hi), 64'h0000_0000_0F0F_0F0F);
    check("mthilo.lo", 64'(mdBus.lo), 64'h0000_0000_0F0F_0F0F);

    // Reset in the middle of a MULTU 3*5.
    mdBus.start   = 1'b1;
    mdBus.op      = MD_MULTU;
    mdBus.rs_data = 32'd3;
    mdBus.rt_data = 32'd5;
    tick();
    mdBus.start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.busy", 64'(mdBus.busy), 64'd0);
    check("midrst.done", 64'(mdBus.done), 64'd0);
    check("midrst.hi", 64'(mdBus.hi), 64'd0);
    check("midrst.lo", 64'(mdBus.lo), 64'd0);
    doneCnt = 0;
    repeat (40) begin
      tick();
      if (mdBus.done) doneCnt++;
    end
    check("midrst.no_done", 64'(doneCnt), 64'd0);
    check("midrst.hi_after", 64'(mdBus.hi), 64'd0);
    check("midrst.lo_after", 64'(mdBus.lo), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
